// File: rtl/ext_sbit_sequencer_if.sv
// ext_sbit_sequencer_if
//   Groups the configuration write port, the scan control port and the
//   registered S-bit channel outputs of ext_sbit_sequencer.
//   master : drives cfg_* / scan_* / dwell_i, observes the outputs
//   slave  : the sequencer itself
//   Ports (all synchronous to the sequencer clock):
//     cfg_wr_i, cfg_addr_i[2:0], cfg_mode_i[1:0], cfg_sel_i[4:0], cfg_ack_o
//     scan_en_i, scan_start_i, scan_mode_i[1:0], scan_cont_i, dwell_i[15:0]
//     sbit_mode_o[15:0], sbit_sel_o[39:0], busy_o, scan_done_o
interface ext_sbit_sequencer_if;
  logic        cfg_wr_i;
  logic [2:0]  cfg_addr_i;
  logic [1:0]  cfg_mode_i;
  logic [4:0]  cfg_sel_i;
  logic        cfg_ack_o;
  logic        scan_en_i;
  logic        scan_start_i;
  logic [1:0]  scan_mode_i;
  logic        scan_cont_i;
  logic [15:0] dwell_i;
  logic [15:0] sbit_mode_o;
  logic [39:0] sbit_sel_o;
  logic        busy_o;
  logic        scan_done_o;

  modport master (
    output cfg_wr_i, cfg_addr_i, cfg_mode_i, cfg_sel_i,
    output scan_en_i, scan_start_i, scan_mode_i, scan_cont_i, dwell_i,
    input  cfg_ack_o, sbit_mode_o, sbit_sel_o, busy_o, scan_done_o
  );

  modport slave (
    input  cfg_wr_i, cfg_addr_i, cfg_mode_i, cfg_sel_i,
    input  scan_en_i, scan_start_i, scan_mode_i, scan_cont_i, dwell_i,
    output cfg_ack_o, sbit_mode_o, sbit_sel_o, busy_o, scan_done_o
  );
endinterface

// File: rtl/ext_sbit_sequencer.sv
// ext_sbit_sequencer
//   Drives eight external S-bit channel selectors either from a manual
//   configuration bank or from an automatic scan that sweeps all VFAT OR
//   inputs, eta rows or sectors eight at a time, holding each step for a
//   programmable dwell.
//   Ports:
//     clock      : system clock, rising edge
//     reset_n_i  : asynchronous active-low reset
//     bus        : ext_sbit_sequencer_if.slave (config write, scan control,
//                  registered channel mode/select outputs, busy/done)
//   Parameters:
//     NUM_VFATS  : number of VFAT OR inputs swept in mode 00 (<= 32)
//     GE21       : selects GE2/1 eta-row count (2) instead of 8
module ext_sbit_sequencer #(
  parameter int NUM_VFATS = 24,
  parameter bit GE21      = 1'b0
) (
  input logic                  clock,
  input logic                  reset_n_i,
  ext_sbit_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DWELL   = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_q;
  logic [5:0]  base_q;
  logic [15:0] cnt_q;
  logic [15:0] dwell_q;
  logic [1:0]  mode_q;
  logic        cont_q;

  // Manual bank kept in the same packed layout as the outputs.
  logic [15:0] bank_mode_q;
  logic [39:0] bank_sel_q;
  logic [15:0] bank_mode_nxt;
  logic [39:0] bank_sel_nxt;

  logic [15:0] step_mode;
  logic [39:0] step_sel;
  logic        start_ok;
  logic        more_steps;

  function automatic logic [6:0] scan_limit(input logic [1:0] m);
    case (m)
      2'b00:   return 7'(NUM_VFATS);
      2'b01:   return GE21 ? 7'd2 : 7'd8;
      default: return 7'd6;
    endcase
  endfunction

  // Bank contents including a write in the current cycle, so that a write
  // reaches the outputs in the same edge as it lands in the bank.
  always_comb begin
    bank_mode_nxt = bank_mode_q;
    bank_sel_nxt  = bank_sel_q;
    for (int k = 0; k < 8; k++) begin
      if (bus.cfg_wr_i && (bus.cfg_addr_i == 3'(k))) begin
        bank_mode_nxt[2*k +: 2] = bus.cfg_mode_i;
        bank_sel_nxt[5*k +: 5]  = bus.cfg_sel_i;
      end
    end
  end

  // Scan step: channel k looks at item base+k; items past the limit are off.
  always_comb begin
    logic [6:0] idx;
    idx       = '0;
    step_mode = '0;
    step_sel  = '0;
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, base_q} + 7'(k);
      if (idx < scan_limit(mode_q)) begin
        step_mode[2*k +: 2] = mode_q;
        step_sel[5*k +: 5]  = idx[4:0];
      end else begin
        step_mode[2*k +: 2] = 2'b11;
        step_sel[5*k +: 5]  = 5'd0;
      end
    end
  end

  assign start_ok   = bus.scan_start_i && bus.scan_en_i && (bus.scan_mode_i != 2'b11);
  assign more_steps = (({1'b0, base_q} + 7'd8) < scan_limit(mode_q));

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= IDLE;
      base_q          <= '0;
      cnt_q           <= '0;
      dwell_q         <= '0;
      mode_q          <= 2'b11;
      cont_q          <= 1'b0;
      bank_mode_q     <= '1;
      bank_sel_q      <= '0;
      bus.sbit_mode_o <= '1;
      bus.sbit_sel_o  <= '0;
      bus.cfg_ack_o   <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.scan_done_o <= 1'b0;
    end else begin
      bank_mode_q     <= bank_mode_nxt;
      bank_sel_q      <= bank_sel_nxt;
      bus.cfg_ack_o   <= bus.cfg_wr_i;
      bus.scan_done_o <= 1'b0;

      if (state_q == IDLE) begin
        bus.sbit_mode_o <= bank_mode_nxt;
        bus.sbit_sel_o  <= bank_sel_nxt;
        if (start_ok) begin
          state_q    <= LOAD;
          base_q     <= '0;
          mode_q     <= bus.scan_mode_i;
          cont_q     <= bus.scan_cont_i;
          dwell_q    <= bus.dwell_i;
          bus.busy_o <= 1'b1;
        end
      end else if (!bus.scan_en_i) begin
        // Abort: straight back to manual outputs, no completion pulse.
        state_q         <= IDLE;
        bus.busy_o      <= 1'b0;
        bus.sbit_mode_o <= bank_mode_nxt;
        bus.sbit_sel_o  <= bank_sel_nxt;
      end else begin
        case (state_q)
          LOAD: begin
            state_q         <= DWELL;
            bus.sbit_mode_o <= step_mode;
            bus.sbit_sel_o  <= step_sel;
            cnt_q           <= dwell_q;
          end
          DWELL: begin
            if (cnt_q == 16'd0) begin
              state_q <= ADVANCE;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          ADVANCE: begin
            if (more_steps) begin
              base_q  <= base_q + 6'd8;
              state_q <= LOAD;
            end else if (cont_q) begin
              base_q  <= '0;
              state_q <= LOAD;
            end else begin
              state_q         <= DONE;
              bus.scan_done_o <= 1'b1;
            end
          end
          DONE: begin
            state_q         <= IDLE;
            bus.busy_o      <= 1'b0;
            bus.sbit_mode_o <= bank_mode_nxt;
            bus.sbit_sel_o  <= bank_sel_nxt;
          end
          default: begin
            state_q    <= IDLE;
            bus.busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_sbit_sequencer.sv
module tb_ext_sbit_sequencer;
  localparam int NV = 24;

  logic clock = 1'b0;
  logic reset_n_i;
  always #5 clock = ~clock;

  ext_sbit_sequencer_if bus();

  ext_sbit_sequencer #(.NUM_VFATS(NV), .GE21(1'b0)) dut (
    .clock(clock),
    .reset_n_i(reset_n_i),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // Reference: manual bank and last-edge acknowledge expectation.
  logic [1:0] m_mode[8];
  logic [4:0] m_sel[8];
  logic       exp_ack;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  function automatic int lim(input int m);
    if (m == 0) return NV;
    if (m == 1) return 8;
    return 6;
  endfunction

  function automatic logic [15:0] man_mode();
    logic [15:0] v;
    for (int k = 0; k < 8; k++) v[2*k +: 2] = m_mode[k];
    return v;
  endfunction

  function automatic logic [39:0] man_sel();
    logic [39:0] v;
    for (int k = 0; k < 8; k++) v[5*k +: 5] = m_sel[k];
    return v;
  endfunction

  // Channel k of scan step s shows item 8*s+k if it exists, otherwise off.
  function automatic logic [15:0] scn_mode(input int m, input int s);
    logic [15:0] v;
    for (int k = 0; k < 8; k++)
      v[2*k +: 2] = (8*s + k < lim(m)) ? 2'(m) : 2'b11;
    return v;
  endfunction

  function automatic logic [39:0] scn_sel(input int m, input int s);
    logic [39:0] v;
    for (int k = 0; k < 8; k++)
      v[5*k +: 5] = (8*s + k < lim(m)) ? 5'(8*s + k) : 5'd0;
    return v;
  endfunction

  task automatic bank_reset();
    for (int k = 0; k < 8; k++) begin
      m_mode[k] = 2'b11;
      m_sel[k]  = 5'd0;
    end
    exp_ack = 1'b0;
  endtask

  task automatic inputs_idle();
    bus.cfg_wr_i     = 1'b0;
    bus.cfg_addr_i   = 3'd0;
    bus.cfg_mode_i   = 2'd0;
    bus.cfg_sel_i    = 5'd0;
    bus.scan_en_i    = 1'b1;
    bus.scan_start_i = 1'b0;
    bus.scan_mode_i  = 2'd0;
    bus.scan_cont_i  = 1'b0;
    bus.dwell_i      = 16'd0;
  endtask

  // Advance one clock, applying any pending write to the reference bank.
  task automatic edge_and_model();
    logic       wr;
    logic [2:0] a;
    logic [1:0] mm;
    logic [4:0] ss;
    wr = bus.cfg_wr_i; a = bus.cfg_addr_i; mm = bus.cfg_mode_i; ss = bus.cfg_sel_i;
    @(posedge clock);
    if (wr) begin
      m_mode[a] = mm;
      m_sel[a]  = ss;
    end
    exp_ack = wr;
    #1;
  endtask

  task automatic rand_write(input int pct);
    bus.cfg_wr_i = ($urandom_range(99, 0) < pct);
    bus.cfg_addr_i = 3'($urandom_range(7, 0));
    bus.cfg_mode_i = 2'($urandom_range(3, 0));
    bus.cfg_sel_i  = 5'($urandom_range(31, 0));
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    inputs_idle();
    bank_reset();
    repeat (3) @(posedge clock);
    #1;
    total++; if (bus.sbit_mode_o !== 16'hFFFF) begin bad++; $display("FAIL reset_mode got=%h exp=%h", bus.sbit_mode_o, 16'hFFFF); end
    total++; if (bus.sbit_sel_o !== 40'h0) begin bad++; $display("FAIL reset_sel got=%h exp=0", bus.sbit_sel_o); end
    total++; if (bus.cfg_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.cfg_ack_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    total++; if (bus.scan_done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.scan_done_o); end
    @(negedge clock);
    reset_n_i = 1'b1;
    edge_and_model();
  endtask

  task automatic test_manual_write();
    bus.cfg_wr_i = 1'b1; bus.cfg_addr_i = 3'd3; bus.cfg_mode_i = 2'b00; bus.cfg_sel_i = 5'd17;
    edge_and_model();
    bus.cfg_wr_i = 1'b0;
    total++; if (bus.cfg_ack_o !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", bus.cfg_ack_o); end
    total++; if (bus.sbit_mode_o !== 16'hFF3F) begin bad++; $display("FAIL wr_mode got=%h exp=%h", bus.sbit_mode_o, 16'hFF3F); end
    total++; if (bus.sbit_sel_o !== 40'h0000088000) begin bad++; $display("FAIL wr_sel got=%h exp=%h", bus.sbit_sel_o, 40'h0000088000); end
    edge_and_model();
    total++; if (bus.cfg_ack_o !== 1'b0) begin bad++; $display("FAIL wr_ack_clear got=%b exp=0", bus.cfg_ack_o); end
    total++; if (bus.sbit_mode_o !== man_mode() || bus.sbit_sel_o !== man_sel()) begin
      bad++; $display("FAIL wr_hold got=%h/%h exp=%h/%h", bus.sbit_mode_o, bus.sbit_sel_o, man_mode(), man_sel());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      bus.cfg_wr_i   = 1'b1;
      bus.cfg_addr_i = 3'($urandom_range(3, 0));   // narrow range forces repeated addresses
      bus.cfg_mode_i = 2'($urandom_range(3, 0));
      bus.cfg_sel_i  = 5'($urandom_range(31, 0));
      edge_and_model();
      total++;
      if ({bus.cfg_ack_o, bus.sbit_mode_o, bus.sbit_sel_o} !== {1'b1, man_mode(), man_sel()}) begin
        bad++;
        $display("FAIL b2b i=%0d got ack=%b mode=%h sel=%h exp ack=1 mode=%h sel=%h",
                 i, bus.cfg_ack_o, bus.sbit_mode_o, bus.sbit_sel_o, man_mode(), man_sel());
      end
    end
    bus.cfg_wr_i = 1'b0;
    edge_and_model();
    total++; if (bus.cfg_ack_o !== 1'b0) begin bad++; $display("FAIL b2b_ack_clear got=%b exp=0", bus.cfg_ack_o); end
  endtask

  // Single-pass scan: step s is visible for j in [1+s*P, (s+1)*P] where j
  // counts edges after the start edge and P = dwell+3; done pulses at j=S*P.
  task automatic test_scan(input int m, input int d);
    int s_cnt, p, j_end;
    logic [15:0] em; logic [39:0] es; logic eb, ed;
    s_cnt = (lim(m) + 7) / 8;
    p = d + 3;
    j_end = s_cnt * p + 3;
    bus.scan_en_i = 1'b1; bus.scan_mode_i = 2'(m); bus.scan_cont_i = 1'b0;
    bus.dwell_i = 16'(d); bus.scan_start_i = 1'b1;
    edge_and_model();
    bus.scan_start_i = 1'b0;
    for (int j = 0; j <= j_end; j++) begin
      eb = (j <= s_cnt * p);
      ed = (j == s_cnt * p);
      if (j >= 1 && j <= s_cnt * p) begin
        em = scn_mode(m, (j - 1) / p); es = scn_sel(m, (j - 1) / p);
      end else begin
        em = man_mode(); es = man_sel();
      end
      total++;
      if ({bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o, bus.cfg_ack_o} !== {em, es, eb, ed, exp_ack}) begin
        bad++;
        $display("FAIL scan m=%0d d=%0d j=%0d got mode=%h sel=%h busy=%b done=%b ack=%b exp mode=%h sel=%h busy=%b done=%b ack=%b",
                 m, d, j, bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o, bus.cfg_ack_o,
                 em, es, eb, ed, exp_ack);
      end
      rand_write(30);
      // Extra start pulses while busy must be ignored.
      bus.scan_start_i = (j < s_cnt * p) && ($urandom_range(3, 0) == 0);
      bus.scan_mode_i  = 2'($urandom_range(3, 0));
      bus.dwell_i      = 16'($urandom_range(9, 0));
      edge_and_model();
    end
    inputs_idle();
  endtask

  task automatic test_ignored_start();
    bus.scan_start_i = 1'b1; bus.scan_mode_i = 2'b11; bus.scan_en_i = 1'b1;
    edge_and_model();
    bus.scan_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL start_mode11 i=%0d busy got=%b exp=0", i, bus.busy_o); end
      edge_and_model();
    end
    bus.scan_start_i = 1'b1; bus.scan_mode_i = 2'b00; bus.scan_en_i = 1'b0;
    edge_and_model();
    inputs_idle();
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL start_en0 busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_continuous_abort();
    int d, p, j_drop;
    logic [15:0] em; logic [39:0] es;
    d = $urandom_range(4, 1);
    p = d + 3;
    j_drop = 3 * p + 1 + $urandom_range(d, 0);   // a cycle inside the fourth step's dwell
    bus.scan_en_i = 1'b1; bus.scan_mode_i = 2'b01; bus.scan_cont_i = 1'b1;
    bus.dwell_i = 16'(d); bus.scan_start_i = 1'b1;
    edge_and_model();
    bus.scan_start_i = 1'b0;
    for (int j = 0; j <= j_drop; j++) begin
      if (j >= 1) begin em = scn_mode(1, 0); es = scn_sel(1, 0); end
      else begin em = man_mode(); es = man_sel(); end
      total++;
      if ({bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o} !== {em, es, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL cont j=%0d got mode=%h sel=%h busy=%b done=%b exp mode=%h sel=%h busy=1 done=0",
                 j, bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o, em, es);
      end
      rand_write(30);
      edge_and_model();
    end
    bus.cfg_wr_i = 1'b0;
    bus.scan_en_i = 1'b0;
    edge_and_model();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o} !== {man_mode(), man_sel(), 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL abort i=%0d got mode=%h sel=%h busy=%b done=%b exp mode=%h sel=%h busy=0 done=0",
                 i, bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o, man_mode(), man_sel());
      end
      edge_and_model();
    end
    inputs_idle();
  endtask

  task automatic test_reset_mid_scan();
    bus.scan_en_i = 1'b1; bus.scan_mode_i = 2'b00; bus.scan_cont_i = 1'b0;
    bus.dwell_i = 16'd5; bus.scan_start_i = 1'b1;
    edge_and_model();
    bus.scan_start_i = 1'b0;
    edge_and_model();
    edge_and_model();
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL pre_reset busy got=%b exp=1", bus.busy_o); end
    #2;
    reset_n_i = 1'b0;
    #1;
    bank_reset();
    total++; if (bus.sbit_mode_o !== 16'hFFFF) begin bad++; $display("FAIL async_rst_mode got=%h exp=ffff", bus.sbit_mode_o); end
    total++; if (bus.sbit_sel_o !== 40'h0) begin bad++; $display("FAIL async_rst_sel got=%h exp=0", bus.sbit_sel_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b exp=0", bus.busy_o); end
    @(posedge clock);
    @(negedge clock);
    reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_and_model();
      total++;
      if ({bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o} !== {16'hFFFF, 40'h0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL post_rst i=%0d got mode=%h sel=%h busy=%b done=%b exp mode=ffff sel=0 busy=0 done=0",
                 i, bus.sbit_mode_o, bus.sbit_sel_o, bus.busy_o, bus.scan_done_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_write();
    test_back_to_back();
    test_scan(0, 4);
    test_scan(2, 0);
    test_scan(1, 2);
    for (int i = 0; i < 4; i++) test_scan($urandom_range(2, 0), $urandom_range(5, 0));
    test_ignored_start();
    test_continuous_abort();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_sbit_sequencer.md
EXT_SBIT_SEQUENCER -- requirements
Module: ext_sbit_sequencer

Interface
REQ-001 Parameter NUM_VFATS, default 24, is the number of VFAT OR inputs addressable in mode 2'b00 (scan limit).
REQ-002 Parameter GE21, default 0: when 1, mode 2'b01 limit is 2 and mode 2'b10 limit is 6; when 0, limits are 8 and 6.
REQ-003 clock  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset_n_i  input  1  reset, asynchronous and active-low; asserted when 0.
REQ-005 cfg_wr_i  input  1  one-cycle write strobe for a manual channel setting.
REQ-006 cfg_addr_i  input  3  channel index 0-7 for the write.
REQ-007 cfg_mode_i  input  2  manual mode: 00 VFAT OR, 01 eta row, 10 sector, 11 off.
REQ-008 cfg_sel_i  input  5  manual select value.
REQ-009 cfg_ack_o  output  1  one-cycle acknowledge of a write.
REQ-010 scan_en_i  input  1  scan enable level; 0 aborts any scan.
REQ-011 scan_start_i  input  1  one-cycle scan start request.
REQ-012 scan_mode_i  input  2  mode swept by the scan, latched at start; 11 is invalid.
REQ-013 scan_cont_i  input  1  1 = wrap and repeat forever; 0 = single pass; latched at start.
REQ-014 dwell_i  input  16  dwell count per step, latched at start.
REQ-015 sbit_mode_o  output  16  channel k mode at bits [2k+1:2k], registered.
REQ-016 sbit_sel_o  output  40  channel k select at bits [5k+4:5k], registered.
REQ-017 busy_o  output  1  high in any state except IDLE.
REQ-018 scan_done_o  output  1  one-cycle pulse at single-pass completion.

Function
REQ-019 Manual bank: 8 entries of {mode[1:0], sel[4:0]}; cfg_wr_i at edge N writes entry cfg_addr_i and drives cfg_ack_o high for the cycle after N, in every state.
REQ-020 Back-to-back writes on consecutive cycles are all accepted and each acknowledged; last write to the same address wins.
REQ-021 FSM states: IDLE, LOAD, DWELL, ADVANCE, DONE.
REQ-022 IDLE -> LOAD when scan_start_i=1, scan_en_i=1 and scan_mode_i!=11; base index cleared to 0; otherwise start is ignored.
REQ-023 LOAD -> DWELL unconditionally; at that edge outputs take the scan step and the dwell counter loads dwell_i.
REQ-024 Scan step for channel k: idx = base+k; if idx < limit(mode) then mode=scan mode, sel=idx[4:0]; else mode=11, sel=0.
REQ-025 Limits: mode 00 -> NUM_VFATS; mode 01 -> 8 (2 if GE21); mode 10 -> 6.
REQ-026 DWELL decrements the counter each cycle; counter==0 -> ADVANCE; DWELL lasts dwell_i+1 cycles; dwell_i=0 is legal (1 cycle).
REQ-027 ADVANCE: if base+8 < limit then base += 8, -> LOAD; else if scan_cont -> base=0, LOAD; else -> DONE.
REQ-028 Each scan step is held on the outputs for exactly dwell_i+3 cycles before the next step appears.
REQ-029 DONE: scan_done_o=1 for one cycle, -> IDLE; outputs revert to the manual bank at the DONE->IDLE edge.
REQ-030 In IDLE, outputs equal the manual bank registered; a write is visible on outputs 1 cycle after its strobe.
REQ-031 During a scan, manual writes update the bank only; outputs show the scan step until scan exit.
REQ-032 scan_en_i=0 in any non-IDLE state -> IDLE at the next edge, no scan_done_o; outputs revert to manual bank at that edge.
REQ-033 scan_start_i while busy_o=1 is ignored.
REQ-034 base index width 6 bits; no overflow occurs for NUM_VFATS <= 32.

Reset
REQ-035 While reset_n_i=0: state IDLE, base=0, counter=0, all manual entries {11, 0}, sbit_mode_o=16'hFFFF, sbit_sel_o=0, cfg_ack_o=0, busy_o=0, scan_done_o=0.
REQ-036 Reset asserted mid-scan takes effect immediately (asynchronously); after release the block is in IDLE and ignores no-longer-present start pulses.

Verification
REQ-037 Reset release, write ch3 {00, 5'd17} -> cfg_ack_o high next cycle; sbit_mode_o[7:6]=00, sbit_sel_o[19:15]=17; all other channels mode 11.
REQ-038 Scan mode 00, NUM_VFATS=24, dwell 4, single -> steps base 0/8/16 each held 7 cycles, ch k sel = base+k, then scan_done_o pulse, outputs return to manual bank.
REQ-039 Scan mode 10, dwell 0 -> one step: ch0-5 mode 10 sel 0-5, ch6-7 mode 11 sel 0; done after ADVANCE.
REQ-040 Continuous scan mode 01, then drop scan_en_i during DWELL -> IDLE next edge, busy_o=0, no scan_done_o, manual outputs restored.
REQ-041 scan_start_i with scan_mode_i=11, and a second start while busy -> both ignored; simultaneous cfg_wr_i during scan acknowledged and visible only after scan end.
REQ-042 Assert reset_n_i=0 mid-DWELL -> outputs immediately sbit_mode_o=16'hFFFF, sbit_sel_o=0, busy_o=0.
